vvp_acc: RTL

//  Pipelined, parametrised vector-vector product with multi-beat accumulation.

---
 rtl/vvp_acc.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/vvp_acc.sv
// vvp_acc: pipelined vector-vector product of N signed activations with N
// 1-bit weights, reduced through a balanced adder tree with optional level
// registers, then accumulated over a first..last frame into an ACCW-bit sum.

// Per-lane weight application: one signed activation, one weight bit.
module vvp_lane #(
  parameter int DW = 2
) (
  input  logic [1:0]    mode,
  input  logic          w,
  input  logic [DW-1:0] d,
  output logic [DW:0]   p
);
  // One extra bit so negating the most negative activation stays exact.
  logic signed [DW:0] dx;
  assign dx = (DW+1)'($signed(d));

  // Select +D, -D or 0 from the weight bit under the current mode.
  always_comb begin
    p = '0;
    unique case (mode)
      2'b00:   p = w ? -dx : dx;
      2'b01:   p = w ? dx : '0;
      2'b10:   p = w ? -dx : '0;
      default: p = '0;
    endcase
  end
endmodule

module vvp_acc #(
  parameter int          N    = 64,
  parameter int          DW   = 2,
  parameter int          ACCW = 24,
  parameter logic [31:0] PR   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_first,
  input  logic             in_last,
  input  logic [1:0]       mode,
  input  logic [N-1:0]     W,
  input  logic [N*DW-1:0]  D,
  output logic             out_valid,
  output logic [ACCW-1:0]  out_sum,
  output logic             out_ovf
);
  localparam int C  = $clog2(N);
  localparam int SW = DW + 1 + C;

  // Level k holds ceil(N/2^k) nodes of width DW+1+k; node j covers the
  // aligned lane block [j*2^k, (j+1)*2^k). A node without a right sibling
  // is passed up sign-extended, which reproduces the low-power-of-two split.
  // Sideband bits: [2]=valid, [1]=first, [0]=last.
  for (genvar k = 0; k <= C; k++) begin : g_lvl
    localparam int CNT = (N + (1 << k) - 1) >> k;
    localparam int WK  = DW + 1 + k;

    logic [CNT-1:0][WK-1:0] sum;
    logic [CNT-1:0][WK-1:0] q;
    logic [2:0]             sb_d;
    logic [2:0]             sb_q;

    if (k == 0) begin : g_leaf
      for (genvar i = 0; i < N; i++) begin : g_ln
        vvp_lane #(.DW(DW)) u_lane (
          .mode (mode),
          .w    (W[i]),
          .d    (D[i*DW +: DW]),
          .p    (sum[i])
        );
      end
      assign sb_d = {in_valid, in_first, in_last};
    end else begin : g_node
      localparam int PCNT = (N + (1 << (k-1)) - 1) >> (k-1);
      for (genvar j = 0; j < CNT; j++) begin : g_nd
        if (2*j+1 < PCNT) begin : g_add
          assign sum[j] = WK'($signed(g_lvl[k-1].q[2*j]))
                        + WK'($signed(g_lvl[k-1].q[2*j+1]));
        end else begin : g_pass
          assign sum[j] = WK'($signed(g_lvl[k-1].q[2*j]));
        end
      end
      assign sb_d = g_lvl[k-1].sb_q;
    end

    if (PR[k]) begin : g_reg
      // Sideband pipeline stage; valid must clear so reset drops in-flight beats.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) sb_q <= '0;
        else     sb_q <= sb_d;
      end
      // Data stage only loads on valid beats; contents are don't-care otherwise.
      always_ff @(posedge clk) begin
        if (sb_d[2]) q <= sum;
      end
    end else begin : g_wire
      assign q    = sum;
      assign sb_q = sb_d;
    end
  end

  logic [SW-1:0] root;
  logic          rv, rf, rl;
  assign root = g_lvl[C].q[0];
  assign rv   = g_lvl[C].sb_q[2];
  assign rf   = g_lvl[C].sb_q[1];
  assign rl   = g_lvl[C].sb_q[0];

  logic signed [ACCW-1:0] acc, root_x, add, nacc;
  logic                   ovf, active, add_ovf, take, novf;

  // Next accumulator value and sticky overflow for the beat at the root.
  always_comb begin
    root_x  = ACCW'($signed(root));
    add     = acc + root_x;
    add_ovf = (acc[ACCW-1] == root_x[ACCW-1]) && (add[ACCW-1] != acc[ACCW-1]);
    take    = rv && (rf || active);
    nacc    = rf ? root_x : add;
    novf    = rf ? 1'b0 : (ovf | add_ovf);
  end

  // Frame accumulation; a first beat always restarts, orphan beats are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      ovf       <= 1'b0;
      active    <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      out_valid <= take && rl;
      if (take) begin
        acc    <= nacc;
        ovf    <= novf;
        active <= !rl;
        if (rl) begin
          out_sum <= nacc;
          out_ovf <= novf;
        end
      end
    end
  end
endmodule
